i2c_touch_target_model: RTL and testbench
=========================================

Name: i2c_touch_target_model

Overview:
- Clock-oversampled I2C target that emulates a capacitive touchscreen controller for Team 08 chip-level DV.
- It replaces hand-toggled interrupt and tied-high SDA/SCL stimulus. It presents NUM_POINTS touch points in a register map, drives active-low int_n when new touch data is committed, and answers register-pointer writes and auto-incrementing reads.
- It connects to the mprj_io interrupt pin and to the I2C SDA/SCL pins of the chip top-level bench.

Parameters:
- I2C_ADDR, 7'h38, 7-bit target address.
- NUM_POINTS, 2, number of touch points (1..5).
- FILTER_LEN, 3, consecutive identical samples required to accept an SCL/SDA level.
- INT_PULSE_CYCLES, 100, int_n low time in pulse mode (macro only).

Ports:
- clk  in  1  oversampling clock, ≥10x SCL rate.
- rst  in  1  asynchronous, active-high reset.
- scl_i  in  1  raw SCL pin level.
- sda_i  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- int_n  out  1  touch interrupt, active low.
- touch_valid  in  1  new touch frame offered.
- touch_ready  out  1  frame accepted when valid&ready.
- touch_count  in  4  number of active points.
- touch_x  in  12*NUM_POINTS  X coordinate per point; point i at [12i+11:12i].
- touch_y  in  12*NUM_POINTS  Y coordinate per point; same packing as touch_x.
- busy  out  1  FSM not IDLE.
- rd_done  out  1  1-cycle pulse on STOP that ends a read transaction.

Behaviour:
- Inputs pass a 2-flop synchronizer, then a FILTER_LEN glitch filter. Edges are detected on the filtered levels only.
- START: filtered SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are legal in any state; a START outside IDLE is a repeated start.
- FSM states: IDLE, ADDR, ACK_ADDR, WR_PTR, ACK_PTR, WR_IGNORE, RD_BYTE, RD_ACK, WAIT_STOP.
  - IDLE→ADDR on START.
  - ADDR: shift 8 bits, MSB first, sampled on SCL rise. Address match → ACK_ADDR. Mismatch → WAIT_STOP with no ack.
  - ACK_ADDR: sda_oe=1 from the SCL fall after bit 8 until the next SCL fall. Then RW=0 → WR_PTR; RW=1 → RD_BYTE.
  - WR_PTR: receive pointer byte → ACK_PTR (acked), then WR_IGNORE. Further bytes are acked and discarded.
  - RD_BYTE: drive each bit on SCL fall (sda_oe = ~bit), MSB first. After bit 8 → RD_ACK with SDA released. Pointer increments and wraps 0xFF→0x00.
  - RD_ACK: sample SDA on SCL rise. ACK → RD_BYTE. NACK → WAIT_STOP.
  - Any STOP → IDLE with sda_oe=0.
- sda_oe updates 1 clk after the filtered SCL-fall detect. Pin-to-pin latency is 3+FILTER_LEN clk.
- Register map:
  - 0x02: touch count, clamped to NUM_POINTS.
  - Point i base = 0x03+6i: XH = {2'b00 (press), 2'b00, x[11:8]}; XL = x[7:0]; YH = {id=i[3:0], y[11:8]}; YL = y[7:0]; +4 = 0x00; +5 = 0x00.
  - All unmapped addresses read 0x00.
  - Points ≥ clamped count read XH=8'h40 (no-event), all other bytes 0.
- Touch frame handling:
  - touch_ready=1 when the 1-deep pending buffer is empty.
  - On the handshake, capture into pending.
  - Commit pending→map only on a cycle with FSM in IDLE (no mid-read tearing). Commit frees the buffer (ready=1 the next cycle) and sets int_n=0.
- Level mode (default): int_n returns 1 on the STOP of a read transaction whose bytes included register 0x02. A commit that coincides with that STOP keeps int_n=0.
- Reset, including mid-transfer:
  - Outputs: sda_oe=0, int_n=1, touch_ready=1, busy=0, rd_done=0.
  - Internal: map=0, pointer=0, FSM=IDLE.

Optional Feature:
- Macro: TOUCH_INT_PULSE_EN.
- Defined: each commit drives int_n low for exactly INT_PULSE_CYCLES clk, independent of reads. A commit during a pulse restarts the count.
- Undefined: level mode as above.

Test Plan:
- Reset mid-ACK_ADDR (sda_oe=1), assert rst → sda_oe=0, int_n=1, busy=0 the same cycle.
- touch_count=1, x0=12'h1A5, y0=12'h2C3; bench writes ptr 0x02, repeated START, reads 5 bytes → 01,01,A5,02,C3. int_n goes low after commit and high after STOP; rd_done pulses once.
- Address 0x39 → no ack (SDA high at the 9th clock), FSM in WAIT_STOP, busy=1 until STOP.
- touch_count=9 with NUM_POINTS=2 → reg 0x02 reads 02. Read from ptr 0xFE for 3 bytes → 00,00,00 (wrap to 0x00).
- Offer a frame during a read → ready stays 0 after capture. Map reads the old values until STOP, then commits. A second offer waits for ready.
- With TOUCH_INT_PULSE_EN and INT_PULSE_CYCLES=100: one commit → int_n low exactly 100 clk. A 2-sample glitch on SCL with FILTER_LEN=3 → no bit shifted.

Source files
------------

// File: rtl/i2c_touch_target_model.sv
// i2c_touch_target_model: clock-oversampled I2C target that emulates a
// capacitive touchscreen controller (register map, pointer write, auto-increment
// read, active-low touch interrupt).
// Optional build macro TOUCH_INT_PULSE_EN: int_n becomes a fixed-length low pulse
// of INT_PULSE_CYCLES clk per commit instead of a level cleared by reading 0x02.
// Touch frame handshake: a frame transfers on any clk edge where
// touch_valid && touch_ready; touch_valid must hold its data until then, and
// touch_ready is high exactly when the one-deep pending buffer is empty.
module i2c_touch_target_model #(
  parameter logic [6:0] I2C_ADDR         = 7'h38,
  parameter int         NUM_POINTS       = 2,
  parameter int         FILTER_LEN       = 3,
  parameter int         INT_PULSE_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe,
  output logic                    int_n,
  input  logic                    touch_valid,
  output logic                    touch_ready,
  input  logic [3:0]              touch_count,
  input  logic [12*NUM_POINTS-1:0] touch_x,
  input  logic [12*NUM_POINTS-1:0] touch_y,
  output logic                    busy,
  output logic                    rd_done,
  output logic [3:0]              dbg_state_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, WR_PTR, ACK_PTR, WR_IGNORE, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  if (NUM_POINTS < 1 || NUM_POINTS > 5 || FILTER_LEN < 1 || INT_PULSE_CYCLES < 1) begin : g_bad_cfg
    $error("i2c_touch_target_model: parameter out of range");
  end

  // Index 1 = SCL, index 0 = SDA.
  logic [1:0]            s1_q, s2_q, filt_q, filt_d;
  logic [FILTER_LEN-1:0] win_q [2];

  // Two-flop synchronizer, then a sample window per line; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      filt_q <= 2'b11;
      for (int j = 0; j < 2; j++) win_q[j] <= '1;
    end else begin
      s1_q   <= {scl_i, sda_i};
      s2_q   <= s1_q;
      filt_q <= filt_d;
      for (int j = 0; j < 2; j++) win_q[j] <= (win_q[j] << 1) | FILTER_LEN'(s2_q[j]);
    end
  end

  // Filtered level only moves once the whole window agrees.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      filt_d[j] = (&win_q[j]) ? 1'b1 : (~|win_q[j]) ? 1'b0 : filt_q[j];
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = filt_d[1] & ~filt_q[1];
  assign scl_fall  = ~filt_d[1] & filt_q[1];
  assign start_det = ~filt_d[0] & filt_q[0] & filt_q[1] & filt_d[1];
  assign stop_det  = filt_d[0] & ~filt_q[0] & filt_q[1] & filt_d[1];

  // Frame storage: pending buffer and the committed register map.
  logic                     pend_valid_q;
  logic [3:0]               pend_cnt_q, map_cnt_q;
  logic [12*NUM_POINTS-1:0] pend_x_q, pend_y_q, map_x_q, map_y_q;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       phase_q, phase_d;
  logic [7:0] shift_q, shift_d, shift_in, tx_q, tx_d, ptr_q, ptr_d, rd_data;
  logic       sda_oe_q, sda_oe_d, rd_txn_q, rd_txn_d, rd_done_q, rd_done_d;
  logic       load_byte, commit;

  assign shift_in = {shift_q[6:0], filt_d[0]};
  assign commit   = pend_valid_q && (state_q == IDLE);

  // Register map read mux at the current pointer.
  always_comb begin
    rd_data = 8'h00;
    if (ptr_q == 8'h02) rd_data = {4'h0, map_cnt_q};
    for (int i = 0; i < NUM_POINTS; i++) begin
      if (ptr_q == 8'(3 + 6*i)) rd_data = (4'(i) < map_cnt_q) ? {4'h0, map_x_q[12*i+8 +: 4]} : 8'h40;
      if (ptr_q == 8'(4 + 6*i)) rd_data = (4'(i) < map_cnt_q) ? map_x_q[12*i +: 8] : 8'h00;
      if (ptr_q == 8'(5 + 6*i)) rd_data = (4'(i) < map_cnt_q) ? {4'(i), map_y_q[12*i+8 +: 4]} : 8'h00;
      if (ptr_q == 8'(6 + 6*i)) rd_data = (4'(i) < map_cnt_q) ? map_y_q[12*i +: 8] : 8'h00;
    end
  end

  // Protocol FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      rd_txn_q  <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      rd_txn_q  <= rd_txn_d;
      rd_done_q <= rd_done_d;
    end
  end

  // Next-state logic; STOP and START override whatever state is active.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    rd_txn_d  = rd_txn_q;
    rd_done_d = 1'b0;
    load_byte = 1'b0;
    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      rd_done_d = rd_txn_q;
      rd_txn_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, WR_PTR, WR_IGNORE: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          phase_d   = 1'b0;
          if (bit_cnt_q == 4'd7) begin
            if (state_q == ADDR) state_d = (shift_in[7:1] == I2C_ADDR) ? ACK_ADDR : WAIT_STOP;
            else                 state_d = ACK_PTR;
            if (state_q == WR_PTR) ptr_d = shift_in;
          end
        end
        // Ack is driven from the fall after bit 8 to the following fall.
        ACK_ADDR, ACK_PTR: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            if (state_q == ACK_PTR)  state_d = WR_IGNORE;
            else if (shift_q[0]) begin
              rd_txn_d  = 1'b1;
              load_byte = 1'b1;
              state_d   = RD_BYTE;
            end else state_d = WR_PTR;
          end
        end
        RD_BYTE: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = RD_ACK;
            end else sda_oe_d = ~tx_q[3'd7 - bit_cnt_q[2:0]];
          end
        end
        RD_ACK: begin
          if (!phase_q && scl_rise) begin
            if (filt_d[0]) state_d = WAIT_STOP;
            else           phase_d = 1'b1;
          end
          if (phase_q && scl_fall) begin
            bit_cnt_d = '0;
            load_byte = 1'b1;
            state_d   = RD_BYTE;
          end
        end
        default: ;
      endcase
    end
    if (load_byte) begin
      tx_d     = rd_data;
      ptr_d    = ptr_q + 8'd1;
      sda_oe_d = ~rd_data[7];
    end
  end

  // Capture offered frames; commit to the map only while the bus FSM is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_cnt_q   <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      map_cnt_q    <= '0;
      map_x_q      <= '0;
      map_y_q      <= '0;
    end else if (touch_valid && !pend_valid_q) begin
      pend_valid_q <= 1'b1;
      pend_cnt_q   <= touch_count;
      pend_x_q     <= touch_x;
      pend_y_q     <= touch_y;
    end else if (commit) begin
      pend_valid_q <= 1'b0;
      map_cnt_q    <= (pend_cnt_q > 4'(NUM_POINTS)) ? 4'(NUM_POINTS) : pend_cnt_q;
      map_x_q      <= pend_x_q;
      map_y_q      <= pend_y_q;
    end
  end

  logic int_n_q;

`ifdef TOUCH_INT_PULSE_EN
  localparam int PW = $clog2(INT_PULSE_CYCLES + 1);
  logic [PW-1:0] pulse_cnt_q;

  // Fixed-length low pulse per commit; a new commit restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_n_q     <= 1'b1;
      pulse_cnt_q <= '0;
    end else if (commit) begin
      int_n_q     <= 1'b0;
      pulse_cnt_q <= PW'(INT_PULSE_CYCLES - 1);
    end else if (!int_n_q) begin
      if (pulse_cnt_q == '0) int_n_q <= 1'b1;
      else                   pulse_cnt_q <= pulse_cnt_q - 1'b1;
    end
  end
`else
  logic reg02_rd_q;

  // Remembers whether the current read transaction returned register 0x02.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              reg02_rd_q <= 1'b0;
    else if (stop_det)                    reg02_rd_q <= 1'b0;
    else if (load_byte && ptr_q == 8'h02) reg02_rd_q <= 1'b1;
  end

  // Level interrupt: set by commit, cleared by the STOP of a read that saw 0x02.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        int_n_q <= 1'b1;
    else if (commit)                                int_n_q <= 1'b0;
    else if (stop_det && rd_txn_q && reg02_rd_q)    int_n_q <= 1'b1;
  end
`endif

  assign sda_oe      = sda_oe_q;
  assign int_n       = int_n_q;
  assign touch_ready = ~pend_valid_q;
  assign busy        = (state_q != IDLE);
  assign rd_done     = rd_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_touch_target_model.sv
// Directed bench for i2c_touch_target_model: bit-banged I2C master, frame driver,
// expected-byte queue and a final report.
module tb_i2c_touch_target_model;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1, sda_m = 1'b1;
  logic        sda_oe, int_n, touch_ready, busy, rd_done;
  logic        touch_valid = 1'b0;
  logic [3:0]  touch_count = '0;
  logic [23:0] touch_x = '0, touch_y = '0;
  logic [3:0]  dbg_state;
  logic        sda_line;

  int n_chk = 0, n_fail = 0, rd_done_cnt = 0, rd_done_base = 0;
  logic [7:0] exp_q[$];
  logic [7:0] b;
  logic       ack;
  bit         c_done;

  assign sda_line = sda_m & ~sda_oe;

  i2c_touch_target_model dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .int_n(int_n), .touch_valid(touch_valid), .touch_ready(touch_ready),
    .touch_count(touch_count), .touch_x(touch_x), .touch_y(touch_y),
    .busy(busy), .rd_done(rd_done), .dbg_state_o(dbg_state)
  );

  // Clock and rd_done pulse counter.
  always #5 clk = ~clk;
  always @(negedge clk) if (rd_done) rd_done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q + 4);
  endtask

  task automatic send_bits(input logic [7:0] d, input bit glitch);
    for (int i = 7; i >= 0; i--) begin
      sda_m = d[i];
      if (glitch) begin
        wait_clk(2); scl_m = 1'b1; wait_clk(2); scl_m = 1'b0; wait_clk(Q - 4);
      end else wait_clk(Q);
      scl_m = 1'b1; wait_clk(2*Q);
      scl_m = 1'b0; wait_clk(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit glitch, output logic a);
    send_bits(d, glitch);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    a = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_byte(input bit nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      d[i] = sda_line; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = nack; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
    sda_m = 1'b1;
  endtask

  task automatic check_rd(input logic [7:0] d);
    if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
    else check("rd_byte", d, exp_q.pop_front());
  endtask

  task automatic read_hdr(input logic [7:0] ptr);
    logic a;
    i2c_start();
    send_byte(8'h70, 1'b0, a); check("addr_w_ack", a, 0);
    send_byte(ptr, 1'b0, a);   check("ptr_ack", a, 0);
    i2c_rstart();
    send_byte(8'h71, 1'b0, a); check("addr_r_ack", a, 0);
  endtask

  task automatic read_regs(input logic [7:0] ptr, input int n);
    logic [7:0] d;
    read_hdr(ptr);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      check_rd(d);
    end
    i2c_stop();
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic offer_frame(input logic [3:0] cnt, input logic [23:0] x, input logic [23:0] y);
    int n = 0;
    touch_count = cnt; touch_x = x; touch_y = y; touch_valid = 1'b1;
    while (!touch_ready && n < 5000) begin wait_clk(1); n++; end
    if (n >= 5000) check("offer_timeout", 1, 0);
    wait_clk(1);
    touch_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  initial begin
    int n;
    // Reset state.
    wait_clk(4); rst = 1'b0; wait_clk(2);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_int_n", int_n, 1);
    check("rst_ready", touch_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_done", rd_done, 0);

    // Frame A, pointer write 0x02, repeated START, read 5 bytes.
    offer_frame(4'd1, 24'h0001A5, 24'h0002C3);
`ifdef TOUCH_INT_PULSE_EN
    n = 0;
    while (int_n && n < 20) begin wait_clk(1); n++; end
    check("int_pulse_start", int_n, 0);
    n = 0;
    while (!int_n && n < 1000) begin wait_clk(1); n++; end
    check("int_pulse_len", n, 100);
`else
    wait_clk(3);
    check("a_int_low", int_n, 0);
`endif
    check("a_ready_after_commit", touch_ready, 1);
    rd_done_base = rd_done_cnt;
    foreach (exp_q[i]) ;
    push_exp(8'h01); push_exp(8'h01); push_exp(8'hA5); push_exp(8'h02); push_exp(8'hC3);
    read_regs(8'h02, 5);
    check("a_rd_done_once", rd_done_cnt - rd_done_base, 1);
`ifndef TOUCH_INT_PULSE_EN
    check("a_int_high_after_stop", int_n, 1);
`endif
    check("a_busy_idle", busy, 0);

    // Address 0x39: no ack, parked in WAIT_STOP until STOP.
    rd_done_base = rd_done_cnt;
    i2c_start();
    send_byte(8'h72, 1'b0, ack);
    check("bad_addr_nack", ack, 1);
    wait_clk(2);
    check("bad_addr_state", dbg_state, 4'd8);
    check("bad_addr_busy", busy, 1);
    i2c_stop();
    check("bad_addr_busy_after_stop", busy, 0);
    check("bad_addr_no_rd_done", rd_done_cnt - rd_done_base, 0);

    // Frame D: count 9 clamps to 2, full map dump, then pointer wrap.
    offer_frame(4'd9, 24'hABC123, 24'hDEF456);
    wait_clk(3);
    push_exp(8'h02); push_exp(8'h01); push_exp(8'h23); push_exp(8'h04); push_exp(8'h56);
    push_exp(8'h00); push_exp(8'h00); push_exp(8'h0A); push_exp(8'hBC); push_exp(8'h1D);
    push_exp(8'hEF); push_exp(8'h00);
    read_regs(8'h02, 12);
    push_exp(8'h00); push_exp(8'h00); push_exp(8'h00); push_exp(8'h00); push_exp(8'h02);
    read_regs(8'hFE, 5);

    // Frames offered during a read: no commit until STOP, second offer waits.
    read_hdr(8'h02);
    recv_byte(1'b0, b); check("mid_b0", b, 8'h02);
    offer_frame(4'd1, 24'h000777, 24'h000888);
    wait_clk(3);
    check("mid_ready_after_capture", touch_ready, 0);
    c_done = 1'b0;
    fork
      begin
        offer_frame(4'd2, 24'h8000F0, 24'h00100F);
        c_done = 1'b1;
      end
    join_none
    recv_byte(1'b0, b); check("mid_old_xh", b, 8'h01);
    recv_byte(1'b1, b); check("mid_old_xl", b, 8'h23);
    check("mid_second_offer_blocked", c_done, 0);
    check("mid_ready_still_low", touch_ready, 0);
    i2c_stop();
    n = 0;
    while (!c_done && n < 200) begin wait_clk(1); n++; end
    check("mid_second_offer_done", c_done, 1);
    wait_clk(4);
`ifndef TOUCH_INT_PULSE_EN
    check("mid_int_low_after_commit", int_n, 0);
`endif
    push_exp(8'h02); push_exp(8'h00); push_exp(8'hF0); push_exp(8'h00); push_exp(8'h0F);
    push_exp(8'h00); push_exp(8'h00); push_exp(8'h08); push_exp(8'h00); push_exp(8'h10);
    push_exp(8'h01);
    read_regs(8'h02, 11);

    // 2-sample SCL glitches during every bit must not shift extra bits.
    i2c_start();
    send_byte(8'h70, 1'b1, ack); check("glitch_addr_ack", ack, 0);
    send_byte(8'h04, 1'b1, ack); check("glitch_ptr_ack", ack, 0);
    i2c_rstart();
    send_byte(8'h71, 1'b0, ack); check("glitch_raddr_ack", ack, 0);
    recv_byte(1'b1, b); check("glitch_rd", b, 8'hF0);
    i2c_stop();

    // Reset in the middle of ACK_ADDR.
    offer_frame(4'd1, 24'h000555, 24'h000666);
    wait_clk(3);
    check("pre_rst_int_low", int_n, 0);
    i2c_start();
    send_bits(8'h71, 1'b0);
    sda_m = 1'b1;
    check("pre_rst_sda_oe", sda_oe, 1);
    check("pre_rst_state", dbg_state, 4'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_sda_oe", sda_oe, 0);
    check("mid_rst_int_n", int_n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", touch_ready, 1);
    wait_clk(2);
    rst = 1'b0;
    scl_m = 1'b1;
    wait_clk(2*Q);
    push_exp(8'h00); push_exp(8'h40);
    read_regs(8'h02, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
